// File: rtl/ctrl_types_pkg.sv
// rtl/ctrl_types_pkg.sv - shared request operation encoding for the cache controllers
package ctrl_types_pkg;

  typedef enum logic [1:0] {
    OP_NOOP   = 2'd0,
    OP_READ   = 2'd1,
    OP_UPSERT = 2'd2,
    OP_DELETE = 2'd3
  } operation_e;

endpackage

// File: rtl/lru_controller.sv
// rtl/lru_controller.sv - cache operation controller with LRU age ranking and optional eviction
module lru_controller
  import ctrl_types_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int EVICT_EN    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid_in,
  output logic                   req_ready_out,
  input  operation_e             operation_in,
  input  logic [NUM_ENTRIES-1:0] used,
  input  logic                   hit,
  input  logic [NUM_ENTRIES-1:0] idx_in,
  output logic [NUM_ENTRIES-1:0] idx_out,
  output logic                   select_out,
  output logic                   write_out,
  output logic                   delete_out,
  output logic                   resp_valid_out,
  input  logic                   resp_ready_in,
  output logic [1:0]             resp_status_out,
  output logic [NUM_ENTRIES-1:0] resp_idx_out
);

  localparam int AGE_W = $clog2(NUM_ENTRIES);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_MISS    = 2'b01;
  localparam logic [1:0] ST_FULL    = 2'b10;
  localparam logic [1:0] ST_EVICTED = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_EXEC   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e                 state;
  operation_e             op_q;
  logic [AGE_W-1:0]       age_q [NUM_ENTRIES];
  logic [1:0]             exec_status;
  logic                   touch_q;
  logic                   retire_q;

  logic                   hit_now;
  logic [NUM_ENTRIES-1:0] free_now;
  logic [NUM_ENTRIES-1:0] victim;
  logic [AGE_W-1:0]       target_age;
  logic                   dec_sel;
  logic                   dec_wr;
  logic                   dec_del;
  logic                   dec_touch;
  logic                   dec_retire;
  logic [NUM_ENTRIES-1:0] dec_idx;
  logic [1:0]             dec_status;

  // Victim is the entry ranked oldest; target_age is the rank of the entry being executed on.
  always_comb begin
    victim     = '0;
    target_age = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (age_q[i] == AGE_W'(NUM_ENTRIES - 1)) victim[i] = 1'b1;
      if (idx_out[i]) target_age = target_age | age_q[i];
    end
  end

  // Decisions are taken from the live memory response at the end of LOOKUP, so the
  // EXEC-cycle strobes can be driven straight from registers.
  always_comb begin
    hit_now    = hit && (idx_in != '0);
    free_now   = ~used & (used + NUM_ENTRIES'(1));
    dec_sel    = 1'b0;
    dec_wr     = 1'b0;
    dec_del    = 1'b0;
    dec_touch  = 1'b0;
    dec_retire = 1'b0;
    dec_idx    = '0;
    dec_status = ST_MISS;
    case (op_q)
      OP_READ: begin
        if (hit_now) begin
          dec_sel    = 1'b1;
          dec_idx    = idx_in;
          dec_touch  = 1'b1;
          dec_status = ST_OK;
        end
      end
      OP_UPSERT: begin
        if (hit_now) begin
          dec_wr     = 1'b1;
          dec_idx    = idx_in;
          dec_touch  = 1'b1;
          dec_status = ST_OK;
        end else if (free_now != '0) begin
          dec_wr     = 1'b1;
          dec_idx    = free_now;
          dec_touch  = 1'b1;
          dec_status = ST_OK;
        end else if (EVICT_EN != 0) begin
          dec_wr     = 1'b1;
          dec_idx    = victim;
          dec_touch  = 1'b1;
          dec_status = ST_EVICTED;
        end else begin
          dec_status = ST_FULL;
        end
      end
      OP_DELETE: begin
        if (hit_now) begin
          dec_del    = 1'b1;
          dec_idx    = idx_in;
          dec_retire = 1'b1;
          dec_status = ST_OK;
        end
      end
      default: dec_status = ST_MISS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      op_q            <= OP_NOOP;
      req_ready_out   <= 1'b1;
      select_out      <= 1'b0;
      write_out       <= 1'b0;
      delete_out      <= 1'b0;
      idx_out         <= '0;
      resp_valid_out  <= 1'b0;
      resp_status_out <= ST_OK;
      resp_idx_out    <= '0;
      exec_status     <= ST_OK;
      touch_q         <= 1'b0;
      retire_q        <= 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) age_q[i] <= AGE_W'(i);
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_in && operation_in != OP_NOOP) begin
            op_q          <= operation_in;
            req_ready_out <= 1'b0;
            select_out    <= 1'b1;
            state         <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          select_out  <= dec_sel;
          write_out   <= dec_wr;
          delete_out  <= dec_del;
          idx_out     <= dec_idx;
          exec_status <= dec_status;
          touch_q     <= dec_touch;
          retire_q    <= dec_retire;
          state       <= S_EXEC;
        end
        S_EXEC: begin
          for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (touch_q) begin
              if (idx_out[i]) age_q[i] <= '0;
              else if (age_q[i] < target_age) age_q[i] <= age_q[i] + AGE_W'(1);
            end else if (retire_q) begin
              if (idx_out[i]) age_q[i] <= AGE_W'(NUM_ENTRIES - 1);
              else if (age_q[i] > target_age) age_q[i] <= age_q[i] - AGE_W'(1);
            end
          end
          select_out      <= 1'b0;
          write_out       <= 1'b0;
          delete_out      <= 1'b0;
          idx_out         <= '0;
          touch_q         <= 1'b0;
          retire_q        <= 1'b0;
          resp_valid_out  <= 1'b1;
          resp_status_out <= exec_status;
          resp_idx_out    <= idx_out;
          state           <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready_in) begin
            resp_valid_out  <= 1'b0;
            resp_status_out <= ST_OK;
            resp_idx_out    <= '0;
            req_ready_out   <= 1'b1;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lru_controller.sv
// tb/tb_lru_controller.sv - directed self-checking bench for lru_controller
module tb_lru_controller;
  import ctrl_types_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  operation_e  operation;
  logic [15:0] used;
  logic        hit;
  logic [15:0] idx_in;
  logic        resp_ready;

  logic        req_ready, select_o, write_o, delete_o, resp_valid;
  logic [15:0] idx_o, resp_idx;
  logic [1:0]  resp_status;

  logic        ne_req_ready, ne_select, ne_write, ne_delete, ne_resp_valid;
  logic [15:0] ne_idx, ne_resp_idx;
  logic [1:0]  ne_resp_status;

  logic        ne_wr_seen;
  logic [1:0]  ne_st_seen;
  logic [15:0] ne_ridx_seen;

  int n_checks = 0;
  int n_errors = 0;
  int exp_age [16];

  lru_controller #(.NUM_ENTRIES(16), .EVICT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_in(req_valid), .req_ready_out(req_ready),
    .operation_in(operation), .used(used), .hit(hit), .idx_in(idx_in), .idx_out(idx_o),
    .select_out(select_o), .write_out(write_o), .delete_out(delete_o),
    .resp_valid_out(resp_valid), .resp_ready_in(resp_ready),
    .resp_status_out(resp_status), .resp_idx_out(resp_idx)
  );

  lru_controller #(.NUM_ENTRIES(16), .EVICT_EN(0)) dut_ne (
    .clk(clk), .rst_n(rst_n), .req_valid_in(req_valid), .req_ready_out(ne_req_ready),
    .operation_in(operation), .used(used), .hit(hit), .idx_in(idx_in), .idx_out(ne_idx),
    .select_out(ne_select), .write_out(ne_write), .delete_out(ne_delete),
    .resp_valid_out(ne_resp_valid), .resp_ready_in(resp_ready),
    .resp_status_out(ne_resp_status), .resp_idx_out(ne_resp_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_ages(input string tag);
    logic [15:0] seen;
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s:age%0d", tag, i), 32'(dut.age_q[i]), 32'(exp_age[i]));
      seen[dut.age_q[i]] = 1'b1;
    end
    check({tag, ":perm"}, 32'(seen), 32'hFFFF);
  endtask

  // One full transaction with resp_ready high, optionally stalled in RESP for 'stall' cycles.
  task automatic run_op(input string tag, input operation_e op, input logic [15:0] u,
                        input logic h, input logic [15:0] ii, input logic e_sel,
                        input logic e_wr, input logic e_del, input logic [15:0] e_idx,
                        input logic [1:0] e_st, input int stall);
    @(negedge clk);
    check({tag, ":rdy0"}, 32'(req_ready), 1);
    operation = op; used = u; hit = h; idx_in = ii; req_valid = 1'b1;
    resp_ready = (stall == 0);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ":lk_sel"}, 32'(select_o), 1);
    check({tag, ":lk_wd"}, 32'({write_o, delete_o, req_ready}), 0);
    @(negedge clk);
    check({tag, ":ex_sel"}, 32'(select_o), 32'(e_sel));
    check({tag, ":ex_wr"}, 32'(write_o), 32'(e_wr));
    check({tag, ":ex_del"}, 32'(delete_o), 32'(e_del));
    check({tag, ":ex_idx"}, 32'(idx_o), 32'(e_idx));
    ne_wr_seen = ne_write;
    @(negedge clk);
    ne_st_seen = ne_resp_status;
    ne_ridx_seen = ne_resp_idx;
    check({tag, ":rs_val"}, 32'(resp_valid), 1);
    check({tag, ":rs_st"}, 32'(resp_status), 32'(e_st));
    check({tag, ":rs_idx"}, 32'(resp_idx), 32'(e_idx));
    check({tag, ":rs_strb"}, 32'({select_o, write_o, delete_o, idx_o}), 0);
    if (stall > 0) begin
      req_valid = 1'b1;
      operation = OP_READ;
      for (int c = 0; c < stall; c++) begin
        @(negedge clk);
        check({tag, ":st_val"}, 32'(resp_valid), 1);
        check({tag, ":st_st"}, 32'(resp_status), 32'(e_st));
        check({tag, ":st_idx"}, 32'(resp_idx), 32'(e_idx));
        check({tag, ":st_rdy"}, 32'({req_ready, select_o}), 0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, ":done_val"}, 32'(resp_valid), 0);
    check({tag, ":done_rdy"}, 32'(req_ready), 1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; operation = OP_NOOP; used = '0; hit = 1'b0;
    idx_in = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rdy", 32'(req_ready), 1);
    check("rst_outs", 32'({select_o, write_o, delete_o, resp_valid, idx_o, resp_status, resp_idx}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    exp_age = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    check_ages("reset");

    run_op("ups_empty", OP_UPSERT, 16'h0000, 1'b0, 16'h0000, 0, 1, 0, 16'h0001, 2'b00, 0);
    check_ages("ups_empty");

    run_op("rd_hit", OP_READ, 16'h0001, 1'b1, 16'h0008, 1, 0, 0, 16'h0008, 2'b00, 0);
    exp_age = '{1, 2, 3, 0, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    check_ages("rd_hit");

    run_op("del5", OP_DELETE, 16'hFFFF, 1'b1, 16'h0020, 0, 0, 1, 16'h0020, 2'b00, 0);
    exp_age = '{1, 2, 3, 0, 4, 15, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
    check_ages("del5");

    run_op("evict", OP_UPSERT, 16'hFFFF, 1'b0, 16'h0000, 0, 1, 0, 16'h0020, 2'b11, 0);
    check("noevict_wr", 32'(ne_wr_seen), 0);
    check("noevict_st", 32'(ne_st_seen), 32'h2);
    check("noevict_idx", 32'(ne_ridx_seen), 0);
    exp_age = '{2, 3, 4, 1, 5, 0, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    check_ages("evict");

    run_op("del2", OP_DELETE, 16'hFFDF, 1'b1, 16'h0004, 0, 0, 1, 16'h0004, 2'b00, 0);
    exp_age = '{2, 3, 15, 1, 4, 0, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
    check_ages("del2");

    run_op("del_miss", OP_DELETE, 16'hFFDB, 1'b0, 16'h0000, 0, 0, 0, 16'h0000, 2'b01, 0);
    run_op("hit_idx0", OP_READ, 16'hFFDB, 1'b1, 16'h0000, 0, 0, 0, 16'h0000, 2'b01, 0);
    check_ages("misses");

    run_op("stall", OP_READ, 16'hFFDB, 1'b1, 16'h0002, 1, 0, 0, 16'h0002, 2'b00, 5);
    exp_age = '{3, 0, 15, 2, 4, 1, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
    check_ages("stall");

    @(negedge clk);
    operation = OP_NOOP; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("noop_idle", 32'({req_ready, select_o, resp_valid}), 32'h4);
      @(negedge clk);
    end

    operation = OP_UPSERT; used = '0; hit = 1'b0; idx_in = '0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rstx_wr", 32'(write_o), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstx_drop", 32'({write_o, idx_o, resp_valid}), 0);
    check("rstx_rdy", 32'(req_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rstx_noresp", 32'(resp_valid), 0);
    exp_age = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    check_ages("rstx");

    run_op("evict15", OP_UPSERT, 16'hFFFF, 1'b0, 16'h0000, 0, 1, 0, 16'h8000, 2'b11, 0);
    check("noevict15_st", 32'(ne_st_seen), 32'h2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
